// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LVDS LCD path: hsync/vsync/de and pixel coordinates,
// with an enable handshake that only ever stops on a whole-frame boundary.
module lcd_timing_gen #(
  parameter int H_ACTIVE        = 1366,
  parameter int H_BLANK         = 169,
  parameter int H_SYNC_START    = 0,
  parameter int H_SYNC_LEN      = 169,
  parameter int V_ACTIVE        = 768,
  parameter int V_BLANK         = 12,
  parameter int V_SYNC_START    = 0,
  parameter int V_SYNC_LEN      = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        running,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  // 12-bit bounds so a window ending exactly at 2048 still compares correctly
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_SYNC_START);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_SYNC_START + H_SYNC_LEN);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_SYNC_START);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_SYNC_START + V_SYNC_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_last;
  logic [10:0] w_x_nxt;
  logic [10:0] w_y_nxt;
  logic        w_run_nxt;
  logic        w_de_nxt;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_ls_nxt;
  logic        w_fs_nxt;

  assign w_last = (pos_x == H_LAST) && (pos_y == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Dropping enable only arms the stop; the stop itself happens on the last pixel
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_RUN;
      S_RUN:   if (!enable) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (enable)      w_state_nxt = S_RUN;
        else if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed for the position shown next cycle, then registered together
  always_comb begin
    w_x_nxt = '0;
    w_y_nxt = '0;
    if (r_state != S_IDLE && w_state_nxt != S_IDLE) begin
      if (pos_x == H_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (pos_y == V_LAST) ? 11'd0 : pos_y + 11'd1;
      end else begin
        w_x_nxt = pos_x + 11'd1;
        w_y_nxt = pos_y;
      end
    end
    w_run_nxt = (w_state_nxt != S_IDLE);
    w_de_nxt  = w_run_nxt && ({1'b0, w_x_nxt} < H_ACT) && ({1'b0, w_y_nxt} < V_ACT);
    w_hs_act  = w_run_nxt && ({1'b0, w_x_nxt} >= HS_BEG) && ({1'b0, w_x_nxt} < HS_END);
    w_vs_act  = w_run_nxt && ({1'b0, w_y_nxt} >= VS_BEG) && ({1'b0, w_y_nxt} < VS_END);
    w_ls_nxt  = w_run_nxt && (w_x_nxt == 11'd0);
    w_fs_nxt  = w_ls_nxt && (w_y_nxt == 11'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      hsync       <= SYNC_ACTIVE_LOW;
      vsync       <= SYNC_ACTIVE_LOW;
      de          <= 1'b0;
      pos_x       <= '0;
      pos_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      running     <= w_run_nxt;
      hsync       <= w_hs_act ^ SYNC_ACTIVE_LOW;
      vsync       <= w_vs_act ^ SYNC_ACTIVE_LOW;
      de          <= w_de_nxt;
      pos_x       <= w_x_nxt;
      pos_y       <= w_y_nxt;
      line_start  <= w_ls_nxt;
      frame_start <= w_fs_nxt;
      if (w_fs_nxt) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
